// File: rtl/calc_sequencer.sv
// calc_sequencer: serial nibble collector that drives a calculator and returns its result
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_data    4-bit nibble stream (A, B, opcode), in_ready back-pressure
//   a, b, oper          registered operands/opcode to the calculator
//   calc_out            combinational calculator result
//   res_valid/res_data  captured result, res_ready from downstream
//   err_op              one-cycle pulse on an illegal opcode nibble
//   res_count           delivered results, modulo 256
module calc_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] oper,
  input  logic [7:0] calc_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       err_op,
  output logic [7:0] res_count
);
  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EVAL   = 3'd3,
    HOLD   = 3'd4
  } state_t;
  state_t     state_q;
  logic [3:0] cnt_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [2:0] oper_q;
  logic [7:0] res_data_q;
  logic       res_valid_q;
  logic       err_op_q;
  logic [7:0] res_count_q;
  assign in_ready  = (state_q == GET_A) || (state_q == GET_B) || (state_q == GET_OP);
  assign a         = a_q;
  assign b         = b_q;
  assign oper      = oper_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign err_op    = err_op_q;
  assign res_count = res_count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GET_A;
      cnt_q       <= 4'd0;
      a_q         <= 4'd0;
      b_q         <= 4'd0;
      oper_q      <= 3'd0;
      res_data_q  <= 8'd0;
      res_valid_q <= 1'b0;
      err_op_q    <= 1'b0;
      res_count_q <= 8'd0;
    end else begin
      err_op_q <= 1'b0;
      case (state_q)
        GET_A: if (in_valid) begin
          a_q     <= in_data;
          state_q <= GET_B;
        end
        GET_B: if (in_valid) begin
          b_q     <= in_data;
          state_q <= GET_OP;
        end
        GET_OP: if (in_valid) begin
          // opcodes with bit 3 set are illegal: drop the whole entry, keep outputs
          if (in_data[3]) begin
            err_op_q <= 1'b1;
            state_q  <= GET_A;
          end else begin
            oper_q  <= in_data[2:0];
            cnt_q   <= 4'(SETTLE_CYCLES - 1);
            state_q <= EVAL;
          end
        end
        EVAL: if (cnt_q == 4'd0) begin
          res_data_q  <= calc_out;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        HOLD: if (res_ready) begin
          res_valid_q <= 1'b0;
          res_count_q <= res_count_q + 8'd1;
          state_q     <= GET_A;
        end
        default: state_q <= GET_A;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench for calc_sequencer with a stub calculator
module tb_calc_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_ready;
  logic [3:0] a, b;
  logic [2:0] oper;
  logic [7:0] calc_out;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic       err_op;
  logic [7:0] res_count;
  logic       s_in_valid = 1'b0;
  logic [3:0] s_in_data = 4'd0;
  logic       s_in_ready;
  logic [3:0] s_a, s_b;
  logic [2:0] s_oper;
  logic [7:0] s_calc_out;
  logic       s_res_valid;
  logic       s_res_ready = 1'b0;
  logic [7:0] s_res_data;
  logic       s_err_op;
  logic [7:0] s_res_count;
  int checks = 0;
  int errors = 0;
  int mdl_cnt = 0;
  int exp_err = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic rnd_rdy = 1'b0;
  logic [7:0] q[$];
  int hs_cyc[$];
  function automatic logic [7:0] calc(input logic [3:0] x, input logic [3:0] y, input logic [2:0] op);
    case (op)
      3'd0: return 8'(x * y);
      3'd1: return 8'(x + y);
      3'd2: return 8'({4'd0, x} - {4'd0, y});
      3'd3: return {x, y};
      3'd4: return {4'd0, x & y};
      3'd5: return {4'd0, x | y};
      3'd6: return {4'd0, x ^ y};
      default: return {4'd0, ~x};
    endcase
  endfunction
  assign calc_out   = calc(a, b, oper);
  assign s_calc_out = calc(s_a, s_b, s_oper);
  calc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .a(a), .b(b), .oper(oper), .calc_out(calc_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .err_op(err_op), .res_count(res_count)
  );
  calc_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .oper(s_oper), .calc_out(s_calc_out), .res_valid(s_res_valid),
    .res_ready(s_res_ready), .res_data(s_res_data), .err_op(s_err_op), .res_count(s_res_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && err_op) err_cnt++;
    if (rst_n && res_valid && res_ready) begin
      hs_cyc.push_back(cyc);
      if (q.size() == 0) check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
      else check("res_data", 32'(res_data), 32'(q.pop_front()));
    end
  end
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) res_ready = 1'($urandom_range(0, 1));
    end
  end
  task automatic send(input logic [3:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic txn(input logic [3:0] x, input logic [3:0] y, input logic [3:0] o);
    send(x);
    send(y);
    if (!o[3]) begin
      q.push_back(calc(x, y, o[2:0]));
      mdl_cnt++;
    end else exp_err++;
    send(o);
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask
  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    mdl_cnt = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    logic [2:0] prev_oper;
    int n;
    #1;
    check("rst_a", 32'(a), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_count", 32'(res_count), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", 32'(in_ready), 1);
    // basic transaction
    txn(4'd9, 4'd3, 4'd0);
    check("basic_a", 32'(a), 32'h9);
    check("basic_b", 32'(b), 32'h3);
    check("basic_oper", 32'(oper), 0);
    check("basic_eval_no_valid", 32'(res_valid), 0);
    @(posedge clk);
    #1;
    check("basic_res_valid", 32'(res_valid), 1);
    check("basic_res_data", 32'(res_data), 32'h1B);
    @(posedge clk);
    #1;
    check("basic_res_count", 32'(res_count), 32'(mdl_cnt));
    // reset asserted while in EVAL
    send(4'd4);
    send(4'd5);
    send(4'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", 32'(a), 0);
    check("mid_rst_b", 32'(b), 0);
    check("mid_rst_oper", 32'(oper), 0);
    check("mid_rst_res_data", 32'(res_data), 0);
    check("mid_rst_res_valid", 32'(res_valid), 0);
    check("mid_rst_err_op", 32'(err_op), 0);
    check("mid_rst_res_count", 32'(res_count), 0);
    #1;
    rst_n = 1'b1;
    mdl_cnt = 0;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_valid", 32'(res_valid), 0);
      @(posedge clk);
      #1;
    end
    // opcode sweep, back to back
    hs_cyc.delete();
    for (int op = 0; op < 8; op++) txn(4'd9, 4'd3, 4'(op));
    drain();
    check("sweep_results", 32'(hs_cyc.size()), 8);
    for (int i = 1; i < hs_cyc.size(); i++) check("sweep_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 5);
    check("sweep_res_count", 32'(res_count), 8);
    // backpressure
    res_ready = 1'b0;
    txn(4'd2, 4'd7, 4'd2);
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_res_valid_rise", 32'(res_valid), 1);
    in_valid = 1'b1;
    in_data  = 4'hC;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_res_valid", 32'(res_valid), 1);
      check("bp_res_data", 32'(res_data), 32'(calc(4'd2, 4'd7, 3'd2)));
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_a_kept", 32'(a), 32'h2);
    end
    res_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check("bp_released", 32'(res_valid), 0);
    check("bp_res_count", 32'(res_count), 32'(mdl_cnt));
    check("bp_queue_empty", 32'(q.size()), 0);
    // illegal opcode
    prev_oper = oper;
    txn(4'd5, 4'd6, 4'b1010);
    check("ill_err_op", 32'(err_op), 1);
    check("ill_in_ready", 32'(in_ready), 1);
    check("ill_oper_kept", 32'(oper), 32'(prev_oper));
    check("ill_a", 32'(a), 32'h5);
    check("ill_b", 32'(b), 32'h6);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("ill_err_op_clear", 32'(err_op), 0);
      check("ill_no_valid", 32'(res_valid), 0);
    end
    // randomized traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) txn(4'($urandom), 4'($urandom), 4'($urandom_range(0, 15)));
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    res_ready = 1'b1;
    drain();
    @(posedge clk);
    #1;
    check("rnd_res_count", 32'(res_count), 32'(8'(mdl_cnt)));
    check("rnd_err_count", 32'(err_cnt), 32'(exp_err));
    // count wrap
    reset_pulse();
    for (int i = 0; i < 255; i++) txn(4'($urandom), 4'($urandom), 4'($urandom_range(0, 7)));
    drain();
    check("wrap_255", 32'(res_count), 255);
    txn(4'd1, 4'd2, 4'd1);
    drain();
    check("wrap_0", 32'(res_count), 0);
    // settle time of 4 on the second instance
    @(posedge clk);
    #1;
    s_in_valid = 1'b1;
    s_in_data  = 4'd7;
    @(posedge clk);
    #1;
    s_in_data = 4'd2;
    @(posedge clk);
    #1;
    s_in_data = 4'd2;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("settle4_in_ready", 32'(s_in_ready), 0);
      @(posedge clk);
      #1;
      check("settle4_res_valid", 32'(s_res_valid), 32'(k == 4));
    end
    check("settle4_res_data", 32'(s_res_data), 32'(calc(4'd7, 4'd2, 3'd2)));
    s_res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("settle4_res_count", 32'(s_res_count), 1);
    check("settle4_done", 32'(s_res_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Upstream operand/opcode sequencer for the 4-bit calculator datapath. It collects operand A, operand B and the opcode as three serial 4-bit nibbles over a valid/ready handshake. It drives them as registered, stable values onto the calculator's `a`/`b`/`oper` inputs, waits a programmable settle time, then captures the calculator's 8-bit `out` and offers it downstream on a second valid/ready handshake. One transaction is in flight at a time.

## Interface
- `SETTLE_CYCLES`, default 1: cycles spent in EVAL before capturing `calc_out`. Legal range is 1..15.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: nibble on `in_data` is valid.
- `in_data` input 4: operand or opcode nibble.
- `in_ready` output 1: sequencer accepts a nibble this cycle.
- `a` output 4: registered operand A, to the calculator.
- `b` output 4: registered operand B, to the calculator.
- `oper` output 3: registered opcode, to the calculator.
- `calc_out` input 8: combinational result from the calculator.
- `res_valid` output 1: `res_data` holds a captured result.
- `res_ready` input 1: downstream accepts the result.
- `res_data` output 8: captured result.
- `err_op` output 1: one-cycle pulse when an illegal opcode nibble is accepted.
- `res_count` output 8: number of results delivered, wraps modulo 256.

## Operation
- States, encoded in 3 bits: GET_A, GET_B, GET_OP, EVAL, HOLD. Reset state is GET_A.
- `in_ready` = 1 in GET_A, GET_B and GET_OP; 0 in EVAL and HOLD.
- A nibble transfer happens on an edge where `in_valid` and `in_ready` are both 1.
- GET_A: a transfer loads `a <= in_data` and moves to GET_B.
- GET_B: a transfer loads `b <= in_data` and moves to GET_OP.
- GET_OP, transfer with `in_data[3]` = 0:
  - `oper <= in_data[2:0]`.
  - Settle counter loads SETTLE_CYCLES-1.
  - State moves to EVAL.
- GET_OP, transfer with `in_data[3]` = 1 (illegal opcode):
  - `err_op` = 1 for the following cycle only.
  - `a`, `b` and `oper` are unchanged.
  - State returns to GET_A; the whole entry is discarded.
- EVAL: the counter decrements each cycle. On the edge where it is 0:
  - `res_data <= calc_out`;
  - `res_valid <= 1`;
  - state moves to HOLD.
- HOLD: `res_valid` = 1 and `res_data` is stable until the edge where `res_ready` = 1. On that edge:
  - `res_valid <= 0`;
  - `res_count <= res_count + 1`, with 255 wrapping to 0;
  - state moves to GET_A.
- `a`, `b` and `oper` hold their values through EVAL and HOLD, and into the next entry until each one is overwritten.
- `in_valid` is ignored in EVAL and HOLD. A nibble offered there is not consumed; upstream holds it.
- `res_ready` is ignored outside HOLD.
- `calc_out` is treated as opaque 8 bits; no width or arithmetic interpretation is made here.
- Illegal state encodings recover to GET_A on the next edge.

## Timing
- Reset: all outputs go to 0 immediately on `rst_n` falling; state is GET_A.
  - Includes `a`, `b`, `oper`, `res_data`, `res_valid`, `err_op` and `res_count`.
  - `in_ready` = 1 in the first cycle after reset.
- Reset mid-transaction, in any state, aborts that transaction. No partial result is ever presented.
- Nibble throughput is one per cycle. A full entry takes at least 3 cycles.
- Opcode-accept edge E0 to `res_valid` rising: SETTLE_CYCLES edges. `res_valid` is high in the cycle following edge E0+SETTLE_CYCLES.
  - With default 1, `res_valid` rises in the cycle right after the opcode-accept cycle.
- `calc_out` is sampled only on the final EVAL edge. `a`/`b`/`oper` are stable for at least SETTLE_CYCLES cycles before that sample.
- If `res_ready` is already high when HOLD is entered, the result is delivered after exactly one HOLD cycle.
- Minimum transaction period with default settings: 5 cycles (3 GET + 1 EVAL + 1 HOLD).

## Test plan
- Reset check: reset asserted mid-EVAL → next cycle all outputs are 0, `in_ready` = 1, no `res_valid` appears.
- Basic transaction (stub `calc_out = a*b`): nibbles 9, 3, 0, then `res_ready` = 1 → `a` = 4'b1001, `b` = 4'b0011, `oper` = 0; `res_data` = 8'h1B one cycle after the opcode; `res_count` = 1.
- Opcode sweep (calculator model attached): a = 9, b = 3, opcodes 0..7 back to back with `res_ready` tied high → 8 results equal to the model output for each `oper`, 5-cycle spacing, `res_count` = 8.
- Backpressure: `res_ready` held low for 10 cycles in HOLD →
  - `res_valid` and `res_data` stay stable;
  - `in_ready` = 0 and a pending `in_valid` nibble is not consumed;
  - releasing `res_ready` delivers exactly once.
- Illegal opcode: nibbles 5, 6, 4'b1010 → `err_op` pulses for 1 cycle, state returns to GET_A, no `res_valid`, `oper` keeps its previous value.
- Settle and wrap: SETTLE_CYCLES = 4 → `res_valid` rises 4 cycles after the opcode-accept edge. Then 256 transactions → `res_count` wraps from 255 to 0.
